// File: rtl/qsfp_bw_sequencer_if.sv
// AXIS TX/RX port bundle between the bandwidth sequencer
// and the QSFP MAC (the far end loops RX back to TX).
interface qsfp_bw_sequencer_if #(
  parameter int DW = 256
);
  logic [DW-1:0] OUT_AXIS_TDATA;
  logic          OUT_AXIS_TVALID;
  logic          OUT_AXIS_TLAST;
  logic          OUT_AXIS_TREADY;
  logic [DW-1:0] IN_AXIS_TDATA;
  logic          IN_AXIS_TVALID;
  logic          IN_AXIS_TLAST;
  logic          IN_AXIS_TREADY;

  modport master (
    output OUT_AXIS_TDATA,
    output OUT_AXIS_TVALID,
    output OUT_AXIS_TLAST,
    input  OUT_AXIS_TREADY,
    input  IN_AXIS_TDATA,
    input  IN_AXIS_TVALID,
    input  IN_AXIS_TLAST,
    output IN_AXIS_TREADY
  );

  modport slave (
    input  OUT_AXIS_TDATA,
    input  OUT_AXIS_TVALID,
    input  OUT_AXIS_TLAST,
    output OUT_AXIS_TREADY,
    output IN_AXIS_TDATA,
    output IN_AXIS_TVALID,
    output IN_AXIS_TLAST,
    input  IN_AXIS_TREADY
  );
endinterface

// File: rtl/qsfp_bw_sequencer.sv
// QSFP loopback bandwidth run: counted AXIS TX generator,
// RX sequence checker, elapsed-time and status report.
module qsfp_bw_sequencer #(
  parameter int DW    = 256,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_xfer_beats,
  input  logic [15:0]      cfg_pkt_beats,
  input  logic [CNT_W-1:0] cfg_timeout,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status,
  output logic [63:0]      xfer_time,
  output logic [CNT_W-1:0] rx_beats,
  output logic [CNT_W-1:0] err_count,
  qsfp_bw_sequencer_if.master axis
);
  typedef enum logic [1:0] {
    IDLE, RUN, DRAIN, REPORT
  } state_t;

  localparam logic [CNT_W-1:0] C1 = CNT_W'(1);
  localparam logic [15:0]      P1 = 16'd1;

  state_t           state;
  logic [CNT_W-1:0] xfer_q;
  logic [CNT_W-1:0] tmo_q;
  logic [CNT_W-1:0] tx_idx;
  logic [CNT_W-1:0] idle_cnt;
  logic [15:0]      pkt_q;
  logic [15:0]      tx_pos;
  logic [15:0]      rx_pos;
  logic [63:0]      cyc;
  logic [63:0]      t0;
  logic             t0_ok;
  logic             abort_f;
  logic             tmo_f;
  logic [31:0]      exp_w;

  logic             tx_hs;
  logic             rx_hs;
  logic             tx_end;
  logic [CNT_W-1:0] nx_idx;
  logic [15:0]      nx_pos;
  logic [15:0]      pkt_in;
  logic [31:0]      rx_w;
  logic             rx_last_exp;
  logic             rx_bad;
  logic [63:0]      t0_eff;

  function automatic logic [DW-1:0] rep(input logic [CNT_W-1:0] n);
    rep = {(DW/32){32'(n)}};
  endfunction

  always_comb begin
    tx_hs  = axis.OUT_AXIS_TVALID && axis.OUT_AXIS_TREADY;
    rx_hs  = axis.IN_AXIS_TVALID && axis.IN_AXIS_TREADY &&
             (state == RUN || state == DRAIN);
    tx_end = tx_idx == xfer_q - C1;
    nx_idx = tx_idx + C1;
    nx_pos = (tx_pos == pkt_q - P1) ? 16'd0 : tx_pos + P1;
    pkt_in = (cfg_pkt_beats == 16'd0) ? P1 : cfg_pkt_beats;
    rx_w   = axis.IN_AXIS_TDATA[31:0];
    rx_last_exp = (rx_pos == pkt_q - P1) ||
                  (rx_beats == xfer_q - C1);
    rx_bad = (rx_w != exp_w) ||
             (axis.IN_AXIS_TLAST != rx_last_exp);
    // RX landing in the same cycle as the first TX beat
    t0_eff = t0_ok ? t0 : cyc;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      status    <= 2'd0;
      xfer_time <= '0;
      rx_beats  <= '0;
      err_count <= '0;
      axis.OUT_AXIS_TDATA  <= '0;
      axis.OUT_AXIS_TVALID <= 1'b0;
      axis.OUT_AXIS_TLAST  <= 1'b0;
      axis.IN_AXIS_TREADY  <= 1'b0;
      xfer_q   <= '0;
      tmo_q    <= '0;
      pkt_q    <= P1;
      tx_idx   <= '0;
      tx_pos   <= '0;
      rx_pos   <= '0;
      idle_cnt <= '0;
      cyc      <= '0;
      t0       <= '0;
      t0_ok    <= 1'b0;
      abort_f  <= 1'b0;
      tmo_f    <= 1'b0;
      exp_w    <= '0;
    end else begin
      cyc  <= cyc + 64'd1;
      done <= 1'b0;
      axis.IN_AXIS_TREADY <= 1'b1;
      if (tx_hs && !t0_ok) begin
        t0    <= cyc;
        t0_ok <= 1'b1;
      end
      if (rx_hs) begin
        rx_beats  <= rx_beats + C1;
        rx_pos    <= (rx_pos == pkt_q - P1) ? 16'd0 : rx_pos + P1;
        // next expected index: +1 on match, resync on mismatch
        exp_w     <= rx_w + 32'd1;
        xfer_time <= cyc - t0_eff;
        if (rx_bad && err_count != '1)
          err_count <= err_count + C1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            xfer_q    <= cfg_xfer_beats;
            pkt_q     <= pkt_in;
            tmo_q     <= cfg_timeout;
            busy      <= 1'b1;
            rx_beats  <= '0;
            err_count <= '0;
            xfer_time <= '0;
            tx_idx    <= '0;
            tx_pos    <= '0;
            rx_pos    <= '0;
            exp_w     <= '0;
            idle_cnt  <= '0;
            t0_ok     <= 1'b0;
            abort_f   <= 1'b0;
            tmo_f     <= 1'b0;
            if (cfg_xfer_beats == '0) begin
              state <= REPORT;
            end else begin
              state <= RUN;
              axis.OUT_AXIS_TVALID <= 1'b1;
              axis.OUT_AXIS_TDATA  <= '0;
              axis.OUT_AXIS_TLAST  <= (pkt_in == P1) ||
                                      (cfg_xfer_beats == C1);
            end
          end
        end
        RUN: begin
          if (abort) begin
            state   <= REPORT;
            abort_f <= 1'b1;
            axis.OUT_AXIS_TVALID <= 1'b0;
          end else if (tx_hs) begin
            if (tx_end) begin
              state    <= DRAIN;
              idle_cnt <= '0;
              axis.OUT_AXIS_TVALID <= 1'b0;
            end else begin
              tx_idx <= nx_idx;
              tx_pos <= nx_pos;
              axis.OUT_AXIS_TDATA <= rep(nx_idx);
              axis.OUT_AXIS_TLAST <= (nx_pos == pkt_q - P1) ||
                                     (nx_idx == xfer_q - C1);
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            state   <= REPORT;
            abort_f <= 1'b1;
          end else if (rx_beats == xfer_q) begin
            state <= REPORT;
          end else if (idle_cnt == tmo_q) begin
            state <= REPORT;
            tmo_f <= 1'b1;
          end else begin
            idle_cnt <= rx_hs ? '0 : idle_cnt + C1;
          end
        end
        REPORT: begin
          state  <= IDLE;
          busy   <= 1'b0;
          done   <= 1'b1;
          status <= abort_f             ? 2'd3 :
                    tmo_f               ? 2'd1 :
                    (err_count != '0)   ? 2'd2 : 2'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qsfp_bw_sequencer.sv
// Directed + randomized bench for qsfp_bw_sequencer with
// a loopback far end and a run-level reference model.
module tb_qsfp_bw_sequencer;
  localparam int DW = 256;
  localparam int CW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] cfg_xfer_beats = '0;
  logic [15:0]   cfg_pkt_beats = '0;
  logic [CW-1:0] cfg_timeout = '0;
  logic          busy;
  logic          done;
  logic [1:0]    status;
  logic [63:0]   xfer_time;
  logic [CW-1:0] rx_beats;
  logic [CW-1:0] err_count;

  qsfp_bw_sequencer_if #(.DW(DW)) axis ();

  qsfp_bw_sequencer #(.DW(DW), .CNT_W(CW)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .abort(abort),
    .cfg_xfer_beats(cfg_xfer_beats),
    .cfg_pkt_beats(cfg_pkt_beats),
    .cfg_timeout(cfg_timeout),
    .busy(busy),
    .done(done),
    .status(status),
    .xfer_time(xfer_time),
    .rx_beats(rx_beats),
    .err_count(err_count),
    .axis(axis)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int ncyc = 0;
  int tx_n = 0;
  int done_cnt = 0;
  int cur_xfer = 0;
  int cur_pkt = 1;
  int tr_mode = 0;
  int rx_pct = 100;
  int corrupt_at = -1;
  int drop_from = -1;
  int rx_wait = 0;
  int lat = 0;
  bit rx_en = 1'b0;
  longint first_tx = -1;
  longint last_rx = -1;
  logic [DW-1:0] lbd[$];
  bit            lbl[$];
  logic [31:0]   rxd[$];
  bit            rxl[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rep(input int n);
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = 32'(n);
    return v;
  endfunction

  task automatic tick();
    bit txh, rxh, stall, held, rst_pre, lx;
    logic [DW-1:0] od, exp_d, d;
    bit ol;
    txh = axis.OUT_AXIS_TVALID && axis.OUT_AXIS_TREADY;
    rxh = axis.IN_AXIS_TVALID && axis.IN_AXIS_TREADY;
    stall = axis.OUT_AXIS_TVALID && !axis.OUT_AXIS_TREADY &&
            !abort && !reset;
    held = axis.IN_AXIS_TVALID && !rxh;
    rst_pre = reset;
    od = axis.OUT_AXIS_TDATA;
    ol = axis.OUT_AXIS_TLAST;
    @(posedge clock);
    ncyc++;
    #1;
    start = 1'b0;
    abort = 1'b0;
    if (done === 1'b1) done_cnt++;
    if (stall) begin
      chk("tx_hold_valid", 64'(axis.OUT_AXIS_TVALID), 64'd1);
      chk("tx_hold_data", axis.OUT_AXIS_TDATA[63:0], od[63:0]);
      chk("tx_hold_last", 64'(axis.OUT_AXIS_TLAST), 64'(ol));
    end
    if (txh && !rst_pre) begin
      exp_d = rep(tx_n);
      lx = ((tx_n + 1) % cur_pkt == 0) || (tx_n == cur_xfer - 1);
      chk("tx_data_lo", od[63:0], exp_d[63:0]);
      chk("tx_data_hi", od[DW-1:DW-64], exp_d[DW-1:DW-64]);
      chk("tx_last", 64'(ol), 64'(lx));
      if (tx_n == 0) first_tx = ncyc;
      if (drop_from < 0 || tx_n < drop_from) begin
        d = od;
        if (tx_n == corrupt_at) d[31:0] = 32'h99;
        lbd.push_back(d);
        lbl.push_back(ol);
      end
      tx_n++;
    end
    if (rxh && !rst_pre && rx_en && lbd.size() > 0) begin
      rxd.push_back(axis.IN_AXIS_TDATA[31:0]);
      rxl.push_back(axis.IN_AXIS_TLAST);
      last_rx = ncyc;
      void'(lbd.pop_front());
      void'(lbl.pop_front());
    end
    if (tr_mode == 0) axis.OUT_AXIS_TREADY = 1'b1;
    else if (tr_mode == 1) axis.OUT_AXIS_TREADY = !axis.OUT_AXIS_TREADY;
    else axis.OUT_AXIS_TREADY = 1'($urandom_range(0, 1));
    if (rx_en && lbd.size() > 0 && tx_n >= rx_wait &&
        (held || $urandom_range(0, 99) < rx_pct)) begin
      axis.IN_AXIS_TVALID = 1'b1;
      axis.IN_AXIS_TDATA  = lbd[0];
      axis.IN_AXIS_TLAST  = lbl[0];
    end else begin
      axis.IN_AXIS_TVALID = 1'b0;
    end
  endtask

  task automatic setup(input int tm, input int pct, input int cor,
                       input int drp, input int wt);
    tr_mode = tm;
    rx_pct = pct;
    corrupt_at = cor;
    drop_from = drp;
    rx_wait = wt;
  endtask

  task automatic launch(input int xf, input int pk, input int tmo);
    cfg_xfer_beats = CW'(xf);
    cfg_pkt_beats = 16'(pk);
    cfg_timeout = CW'(tmo);
    cur_xfer = xf;
    cur_pkt = (pk == 0) ? 1 : pk;
    tx_n = 0;
    first_tx = -1;
    last_rx = -1;
    lbd.delete();
    lbl.delete();
    rxd.delete();
    rxl.delete();
    rx_en = 1'b1;
    done_cnt = 0;
    start = 1'b1;
    tick();
    chk("busy_on_start", 64'(busy), 64'd1);
    chk("tvalid_on_start", 64'(axis.OUT_AXIS_TVALID), 64'(xf != 0));
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (done !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic stop_rx();
    rx_en = 1'b0;
    axis.IN_AXIS_TVALID = 1'b0;
    lbd.delete();
    lbl.delete();
  endtask

  task automatic check_result(input bit aborted);
    int e, err, n, st;
    bit bad_d, lx;
    longint xt;
    e = 0;
    err = 0;
    n = rxd.size();
    for (int k = 0; k < n; k++) begin
      lx = ((k + 1) % cur_pkt == 0) || (k == cur_xfer - 1);
      bad_d = rxd[k] != 32'(e);
      if (bad_d || rxl[k] != lx) err++;
      e = bad_d ? int'(rxd[k]) + 1 : e + 1;
    end
    st = aborted ? 3 : (n < cur_xfer) ? 1 : (err != 0) ? 2 : 0;
    xt = (last_rx < 0) ? 0 : last_rx - first_tx;
    chk("done_seen", 64'(done), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("status", 64'(status), 64'(st));
    chk("rx_beats", 64'(rx_beats), 64'(n));
    chk("err_count", 64'(err_count), 64'(err));
    chk("xfer_time", xfer_time, 64'(xt));
    tick();
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_status"}, 64'(status), 64'd0);
    chk({tag, "_xfer_time"}, xfer_time, 64'd0);
    chk({tag, "_rx_beats"}, 64'(rx_beats), 64'd0);
    chk({tag, "_err_count"}, 64'(err_count), 64'd0);
    chk({tag, "_tvalid"}, 64'(axis.OUT_AXIS_TVALID), 64'd0);
    chk({tag, "_tlast"}, 64'(axis.OUT_AXIS_TLAST), 64'd0);
    chk({tag, "_tdata"}, axis.OUT_AXIS_TDATA[63:0], 64'd0);
    chk({tag, "_in_tready"}, 64'(axis.IN_AXIS_TREADY), 64'd0);
  endtask

  initial begin
    int xf, pk;
    axis.OUT_AXIS_TREADY = 1'b1;
    axis.IN_AXIS_TVALID = 1'b0;
    axis.IN_AXIS_TDATA = '0;
    axis.IN_AXIS_TLAST = 1'b0;

    repeat (3) tick();
    check_zero("reset");
    reset = 1'b0;
    tick();
    chk("in_tready_after_reset", 64'(axis.IN_AXIS_TREADY), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);

    setup(0, 100, -1, -1, 0);
    launch(16, 4, 100);
    wait_done(200);
    check_result(1'b0);
    chk("tx_count_16", 64'(tx_n), 64'd16);

    setup(1, 100, -1, -1, 0);
    launch(8, 3, 100);
    wait_done(200);
    check_result(1'b0);
    chk("tx_count_toggle", 64'(tx_n), 64'd8);

    setup(0, 100, 5, -1, 0);
    launch(8, 3, 100);
    wait_done(200);
    check_result(1'b0);

    setup(0, 100, -1, -1, 1000);
    launch(16, 4, 500);
    for (int i = 0; i < 100 && tx_n < 16; i++) tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_zero("mid_reset");
    reset = 1'b0;
    stop_rx();
    done_cnt = 0;
    repeat (5) tick();
    chk("no_done_after_reset", 64'(done_cnt), 64'd0);
    chk("in_tready_rearmed", 64'(axis.IN_AXIS_TREADY), 64'd1);
    setup(0, 100, -1, -1, 0);
    launch(16, 4, 100);
    wait_done(200);
    check_result(1'b0);

    setup(0, 100, -1, 6, 0);
    launch(8, 4, 100);
    wait_done(400);
    lat = ncyc - int'(last_rx);
    chk("timeout_latency_ok", 64'(lat >= 100 && lat <= 106), 64'd1);
    check_result(1'b0);

    setup(0, 100, -1, -1, 0);
    launch(1000, 8, 100);
    repeat (9) tick();
    abort = 1'b1;
    tick();
    stop_rx();
    chk("abort_tvalid_drop", 64'(axis.OUT_AXIS_TVALID), 64'd0);
    tick();
    check_result(1'b1);

    abort = 1'b1;
    tick();
    chk("idle_abort_busy", 64'(busy), 64'd0);
    chk("idle_abort_done", 64'(done), 64'd0);

    setup(2, 100, -1, -1, 0);
    abort = 1'b1;
    launch(4, 0, 50);
    wait_done(200);
    check_result(1'b0);

    setup(0, 100, -1, -1, 0);
    launch(0, 4, 10);
    wait_done(10);
    check_result(1'b0);

    for (int r = 0; r < 4; r++) begin
      xf = int'($urandom_range(1, 40));
      pk = int'($urandom_range(0, 7));
      setup(2, 60, (r % 2 == 1) ? int'($urandom_range(0, xf - 1)) : -1,
            -1, 0);
      launch(xf, pk, 300);
      wait_done(3000);
      check_result(1'b0);
      chk("tx_count_rand", 64'(tx_n), 64'(xf));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
